// File: rtl/float_fixed_pipe.sv
// float_fixed_pipe: 2-stage IEEE-754 single to signed fixed-point converter with valid/ready flow control.
// Define ROUND_NEAREST_EN for round-to-nearest-even; the default build truncates toward zero.
module float_fixed_pipe #(
  parameter int  INT_BITS  = 1,
  parameter int  FRAC_BITS = 20,
  localparam int W         = 1 + INT_BITS + FRAC_BITS
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic         ovf,
  output logic         inexact,
  output logic         invalid
);

  typedef enum logic [1:0] {K_ZERO, K_NAN, K_SAT, K_NUM} kind_e;

  localparam logic [W-1:0] SAT_POS = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] SAT_NEG = {1'b1, {(W-1){1'b0}}};
  localparam logic [W:0]   MAX_MAG = {2'b00, {(W-1){1'b1}}};
  localparam logic [W:0]   MIN_MAG = {2'b01, {(W-1){1'b0}}};

  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // ---------------- stage 1: classify and align ----------------
  logic         sign_c;
  logic [7:0]   exp_c;
  logic [22:0]  mant_c;
  assign {sign_c, exp_c, mant_c} = data;

  kind_e        kind_c;
  logic [63:0]  wide_c;
  logic [W+1:0] mag4_c;
  logic         lost_c;
  int           sh_c;
  int           amt_c;

  // Magnitude is formed at 4x scale (two guard bits); everything shifted out below folds into lost_c.
  // NOTE: every always_comb output gets a default at the top, so no path can infer a latch.
  always_comb begin
    sh_c   = int'(exp_c) - 150 + FRAC_BITS;
    amt_c  = 30 - sh_c;
    if (amt_c > 63) amt_c = 63;
    if (amt_c < 0)  amt_c = 0;
    wide_c = {8'd0, 1'b1, mant_c, 32'd0};
    mag4_c = (W+2)'(wide_c >> amt_c);
    lost_c = |(wide_c & ((64'd1 << amt_c) - 64'd1));
    if (exp_c == 8'd0)         kind_c = K_ZERO;
    else if (exp_c == 8'hFF)   kind_c = (|mant_c) ? K_NAN : K_SAT;
    else if (sh_c >= W - 23)   kind_c = K_SAT;
    else                       kind_c = K_NUM;
  end

  logic         s1_valid;
  logic         s1_sign;
  kind_e        s1_kind;
  logic [W-1:0] s1_mag;
  logic         s1_guard;
  logic         s1_sticky;

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!rst_n)       s1_valid <= 1'b0;
    else if (advance) s1_valid <= in_valid;
  end

  // NOTE: payload registers are not reset; the valid bits alone qualify them.
  always_ff @(posedge clk) begin
    if (advance && in_valid) begin
      s1_sign   <= sign_c;
      s1_kind   <= kind_c;
      s1_mag    <= mag4_c[W+1:2];
      s1_guard  <= mag4_c[1];
      s1_sticky <= (exp_c == 8'd0) ? (|mant_c) : (mag4_c[0] | lost_c);
    end
  end

  // ---------------- stage 2: round, saturate, sign ----------------
  logic         inc_c;
  logic         pre_big_c;
  logic         ovf_c;
  logic         inexact_c;
  logic [W:0]   rmag_c;
  logic [W-1:0] res_c;

  always_comb begin
`ifdef ROUND_NEAREST_EN
    inc_c = s1_guard & (s1_sticky | s1_mag[0]);
`else
    inc_c = 1'b0;
`endif
    rmag_c    = {1'b0, s1_mag} + {{W{1'b0}}, inc_c};
    pre_big_c = s1_sign ? ({1'b0, s1_mag} > MIN_MAG) : ({1'b0, s1_mag} > MAX_MAG);
    res_c     = '0;
    ovf_c     = 1'b0;
    inexact_c = 1'b0;
    case (s1_kind)
      K_ZERO: inexact_c = s1_sticky;
      K_NAN:  res_c     = '0;
      K_SAT: begin
        res_c = s1_sign ? SAT_NEG : SAT_POS;
        ovf_c = 1'b1;
      end
      default: begin
        ovf_c = s1_sign ? (rmag_c > MIN_MAG) : (rmag_c > MAX_MAG);
        if (ovf_c) begin
          // Saturation reports inexact only when the round-up itself pushed it out of range.
          res_c     = s1_sign ? SAT_NEG : SAT_POS;
          inexact_c = !pre_big_c;
        end else begin
          res_c     = s1_sign ? -rmag_c[W-1:0] : rmag_c[W-1:0];
          inexact_c = s1_guard | s1_sticky;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      ovf       <= 1'b0;
      inexact   <= 1'b0;
      invalid   <= 1'b0;
    end else if (advance) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        result  <= res_c;
        ovf     <= ovf_c;
        inexact <= inexact_c;
        invalid <= (s1_kind == K_NAN);
      end
    end
  end

endmodule

// File: tb/tb_float_fixed_pipe.sv
// Directed bench for float_fixed_pipe: default (W=22) and INT_BITS=7/FRAC_BITS=8 (W=16) instances.
// Expectations follow ROUND_NEAREST_EN when defined.
module tb_float_fixed_pipe;
  localparam int W  = 22;
  localparam int PW = 16;
`ifdef ROUND_NEAREST_EN
  localparam bit RN = 1'b1;
`else
  localparam bit RN = 1'b0;
`endif

  typedef struct {
    logic [31:0] data;
    logic [31:0] res;
    logic [2:0]  flags;  // {ovf, inexact, invalid}
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          in_valid  = 1'b0;
  logic          out_ready = 1'b0;
  logic [31:0]   data      = '0;
  logic          in_ready, out_valid, ovf, inexact, invalid;
  logic [W-1:0]  result;

  logic          p_in_valid  = 1'b0;
  logic          p_out_ready = 1'b0;
  logic [31:0]   p_data      = '0;
  logic          p_in_ready, p_out_valid, p_ovf, p_inexact, p_invalid;
  logic [PW-1:0] p_result;

  float_fixed_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .data(data),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .ovf(ovf), .inexact(inexact), .invalid(invalid)
  );

  float_fixed_pipe #(.INT_BITS(7), .FRAC_BITS(8)) dut_p (
    .clk(clk), .rst_n(rst_n), .in_valid(p_in_valid), .in_ready(p_in_ready), .data(p_data),
    .out_valid(p_out_valid), .out_ready(p_out_ready), .result(p_result),
    .ovf(p_ovf), .inexact(p_inexact), .invalid(p_invalid)
  );

  int   n_vec = 0;
  int   n_err = 0;
  vec_t dv[$];
  vec_t pv[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void add(input bit sel, input logic [31:0] d, input logic [31:0] r,
                              input logic [2:0] f);
    vec_t v;
    v.data  = d;
    v.res   = r;
    v.flags = f;
    if (sel) pv.push_back(v);
    else     dv.push_back(v);
  endfunction

  // One isolated transfer: accepted at edge N, output valid after edge N+1, consumed at edge N+2.
  task automatic run_vec(input bit sel, input vec_t v, input int idx);
    string       tag;
    logic [31:0] r;
    logic [2:0]  f;
    logic        vl, rdy;
    tag = $sformatf("%s[%0d] 0x%08h", sel ? "sweep" : "vec", idx, v.data);
    @(negedge clk);
    if (sel) begin p_data = v.data; p_in_valid = 1'b1; p_out_ready = 1'b1; end
    else     begin data   = v.data; in_valid   = 1'b1; out_ready   = 1'b1; end
    #1;
    rdy = sel ? p_in_ready : in_ready;
    check({tag, " in_ready"}, 32'(rdy), 32'd1);
    @(negedge clk);
    if (sel) p_in_valid = 1'b0;
    else     in_valid   = 1'b0;
    vl = sel ? p_out_valid : out_valid;
    check({tag, " early out_valid"}, 32'(vl), 32'd0);
    @(negedge clk);
    vl = sel ? p_out_valid : out_valid;
    r  = sel ? 32'(p_result) : 32'(result);
    f  = sel ? {p_ovf, p_inexact, p_invalid} : {ovf, inexact, invalid};
    check({tag, " out_valid"}, 32'(vl), 32'd1);
    check({tag, " result"}, r, v.res);
    check({tag, " flags{ovf,inexact,invalid}"}, 32'(f), 32'(v.flags));
  endtask

  function automatic logic [31:0] stream_data(input int i);
    logic [7:0] ex;
    ex = 8'(127 - (i + 1));
    return {i[0], ex, 23'd0};
  endfunction

  function automatic logic [31:0] stream_exp(input int i);
    logic [31:0] m;
    m = 32'd1 << (19 - i);
    return i[0] ? (32'd1 << W) - m : m;
  endfunction

  task automatic run_stream();
    logic [31:0] exp_q[$];
    logic [31:0] prev_res;
    logic [31:0] e;
    bit          prev_stall;
    int          sent;
    int          got;
    prev_stall = 1'b0;
    prev_res   = '0;
    sent       = 0;
    got        = 0;
    for (int cyc = 0; cyc < 80 && got < 8; cyc++) begin
      @(negedge clk);
      if (prev_stall) begin
        check("bp hold out_valid", 32'(out_valid), 32'd1);
        check("bp hold result", 32'(result), prev_res);
      end
      out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
      in_valid  = (sent < 8);
      data      = (sent < 8) ? stream_data(sent) : 32'd0;
      #1;
      check($sformatf("bp in_ready cyc%0d", cyc), 32'(in_ready), 32'(!out_valid || out_ready));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("bp spurious output", 32'(out_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("bp out[%0d]", got), 32'(result), e);
          got++;
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(stream_exp(sent));
        sent++;
      end
      prev_stall = out_valid && !out_ready;
      prev_res   = 32'(result);
    end
    check("bp outputs received", 32'(got), 32'd8);
    check("bp outputs outstanding", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("bp drained", 32'(out_valid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, limit 200000 time units");
    $fatal(1, "watchdog expired");
  end

  initial begin
    add(0, 32'h3F000000, 32'h080000, 3'b000);
    add(0, 32'hBF000000, 32'h380000, 3'b000);
    add(0, 32'h3F800000, 32'h100000, 3'b000);
    add(0, 32'h3F400000, 32'h0C0000, 3'b000);
    add(0, 32'h80000000, 32'h000000, 3'b000);
    add(0, 32'h40000000, 32'h1FFFFF, 3'b100);
    add(0, 32'hC0000000, 32'h200000, 3'b000);
    add(0, 32'hFF800000, 32'h200000, 3'b100);
    add(0, 32'h7F800000, 32'h1FFFFF, 3'b100);
    add(0, 32'h7F7FFFFF, 32'h1FFFFF, 3'b100);
    add(0, 32'h7FC00000, 32'h000000, 3'b001);
    add(0, 32'hFFC00001, 32'h000000, 3'b001);
    add(0, 32'h35000000, 32'h000000, 3'b010);
    add(0, 32'h35400000, RN ? 32'h1 : 32'h0, 3'b010);
    add(0, 32'h35C00000, RN ? 32'h2 : 32'h1, 3'b010);
    add(0, 32'h36200000, 32'h000002, 3'b010);
    add(0, 32'h00000001, 32'h000000, 3'b010);
    add(0, 32'h00800000, 32'h000000, 3'b010);
    add(0, 32'h3FFFFFFF, 32'h1FFFFF, {RN, 2'b10});
    add(0, 32'hBFFFFFFF, RN ? 32'h200000 : 32'h200001, 3'b010);
    add(1, 32'h42FF0000, 32'h7F80, 3'b000);
    add(1, 32'h43000000, 32'h7FFF, 3'b100);
    add(1, 32'hC3000000, 32'h8000, 3'b000);
    add(1, 32'hC3008000, 32'h8000, 3'b100);
    add(1, 32'h3B800000, 32'h0001, 3'b000);

    repeat (3) @(negedge clk);
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset result", 32'(result), 32'd0);
    check("reset flags", 32'({ovf, inexact, invalid}), 32'd0);
    check("reset sweep out_valid", 32'(p_out_valid), 32'd0);
    check("reset sweep in_ready", 32'(p_in_ready), 32'd1);
    rst_n = 1'b1;

    foreach (dv[i]) run_vec(1'b0, dv[i], i);
    foreach (pv[i]) run_vec(1'b1, pv[i], i);

    run_stream();

    // Fill both stages under a stall, then reset for one cycle.
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    data      = 32'h3F800000;
    @(negedge clk);
    data = 32'h3F000000;
    @(negedge clk);
    in_valid = 1'b0;
    check("stall full out_valid", 32'(out_valid), 32'd1);
    check("stall in_ready", 32'(in_ready), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    check("midreset out_valid", 32'(out_valid), 32'd0);
    check("midreset result", 32'(result), 32'd0);
    check("midreset flags", 32'({ovf, inexact, invalid}), 32'd0);
    check("midreset in_ready", 32'(in_ready), 32'd1);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("post-reset no stale output", 32'(out_valid), 32'd0);
    data     = 32'hBF400000;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("post-reset latency early", 32'(out_valid), 32'd0);
    @(negedge clk);
    check("post-reset out_valid", 32'(out_valid), 32'd1);
    check("post-reset result", 32'(result), 32'h340000);
    check("post-reset flags", 32'({ovf, inexact, invalid}), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
